// File: rtl/sr_pkg.sv
// Shared types and default timing constants for the sr_latch driver slice.
//   state_e : driver FSM states (IDLE, PULSE, GAP)
//   cmd_e   : command kind; value equals the latch state it produces
package sr_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PULSE = 2'd1,
      GAP   = 2'd2
   } state_e;

   typedef enum logic {
      CMD_RST = 1'b0,
      CMD_SET = 1'b1
   } cmd_e;

   localparam int unsigned DEF_PULSE_CYC = 2;
   localparam int unsigned DEF_GAP_CYC   = 1;

endpackage

// File: rtl/sr_dcount.sv
// Loadable down-counter with zero flag; shared between pulse and gap timing.
// Ports:
//   clk, rst  : clock and asynchronous active-high reset
//   load      : load load_val this edge (takes priority over dec)
//   load_val  : value to load
//   dec       : decrement this edge; holds at zero
//   cnt       : current count
//   zero      : cnt == 0
module sr_dcount #(
   parameter int unsigned CW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic [CW-1:0] load_val,
   input  logic          dec,
   output logic [CW-1:0] cnt,
   output logic          zero
);

   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= load_val;
      end else if (dec && (cnt_q != '0)) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   assign cnt  = cnt_q;
   assign zero = (cnt_q == '0);

endmodule

// File: rtl/sr_latch_driver.sv
// Sequencer in front of sr_latch: turns level set/reset requests into
// mutually exclusive, fixed-width S/R pulses followed by dead time, then
// compares the fed-back latch output with the expected state.
// Ports:
//   clk, rst        : clock and asynchronous active-high reset
//   set_req/rst_req : level requests, sampled only in IDLE, held until ack
//   q_fb            : latch Q fed back (same clock domain)
//   S, R            : registered latch drives, never both high
//   busy            : high in PULSE and GAP
//   ack             : one cycle, first GAP cycle of a command
//   conflict        : one cycle, both requests seen in IDLE (reset wins)
//   mismatch        : one cycle after GAP when q_fb != q_exp
//   q_exp, q_valid  : expected latch state and whether it is known yet
module sr_latch_driver
   import sr_pkg::*;
#(
   parameter int unsigned PULSE_CYC = DEF_PULSE_CYC,
   parameter int unsigned GAP_CYC   = DEF_GAP_CYC,
   parameter int unsigned CW        = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic set_req,
   input  logic rst_req,
   input  logic q_fb,
   output logic S,
   output logic R,
   output logic busy,
   output logic ack,
   output logic conflict,
   output logic mismatch,
   output logic q_exp,
   output logic q_valid
);

   localparam logic [CW-1:0] PulseLoad = CW'(PULSE_CYC - 1);
   localparam logic [CW-1:0] GapLoad   = CW'(GAP_CYC - 1);

   state_e state_q, state_d;
   cmd_e   cmd_q, cmd_d;

   logic          cnt_load, cnt_dec, cnt_zero;
   logic [CW-1:0] cnt_val, cnt;

   logic s_q, s_d, r_q, r_d, busy_q, busy_d, ack_q, ack_d;
   logic conflict_q, conflict_d, mismatch_q, mismatch_d;
   logic q_exp_q, q_exp_d, q_valid_q, q_valid_d;

   sr_dcount #(
      .CW (CW)
   ) u_dcount (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load),
      .load_val (cnt_val),
      .dec      (cnt_dec),
      .cnt      (cnt),
      .zero     (cnt_zero)
   );

   // State and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         cmd_q      <= CMD_RST;
         s_q        <= 1'b0;
         r_q        <= 1'b0;
         busy_q     <= 1'b0;
         ack_q      <= 1'b0;
         conflict_q <= 1'b0;
         mismatch_q <= 1'b0;
         q_exp_q    <= 1'b0;
         q_valid_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cmd_q      <= cmd_d;
         s_q        <= s_d;
         r_q        <= r_d;
         busy_q     <= busy_d;
         ack_q      <= ack_d;
         conflict_q <= conflict_d;
         mismatch_q <= mismatch_d;
         q_exp_q    <= q_exp_d;
         q_valid_q  <= q_valid_d;
      end
   end

   // Next state and counter control
   always_comb begin
      state_d  = state_q;
      cmd_d    = cmd_q;
      cnt_load = 1'b0;
      cnt_val  = '0;
      cnt_dec  = 1'b0;
      unique case (state_q)
         IDLE: begin
            // Reset has priority over set
            if (rst_req) begin
               state_d  = PULSE;
               cmd_d    = CMD_RST;
               cnt_load = 1'b1;
               cnt_val  = PulseLoad;
            end else if (set_req) begin
               state_d  = PULSE;
               cmd_d    = CMD_SET;
               cnt_load = 1'b1;
               cnt_val  = PulseLoad;
            end
         end
         PULSE: begin
            if (cnt_zero) begin
               state_d  = GAP;
               cnt_load = 1'b1;
               cnt_val  = GapLoad;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         GAP: begin
            if (cnt_zero) begin
               state_d = IDLE;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Registered outputs derived from the upcoming state so they align with it
   always_comb begin
      s_d        = (state_d == PULSE) && (cmd_d == CMD_SET);
      r_d        = (state_d == PULSE) && (cmd_d == CMD_RST);
      busy_d     = (state_d != IDLE);
      ack_d      = (state_q == PULSE) && (state_d == GAP);
      conflict_d = (state_q == IDLE) && set_req && rst_req;
      mismatch_d = (state_q == GAP) && (state_d == IDLE) && (q_fb != q_exp_q);
      q_exp_d    = ack_d ? logic'(cmd_q) : q_exp_q;
      q_valid_d  = q_valid_q | ack_d;
   end

   assign S        = s_q;
   assign R        = r_q;
   assign busy     = busy_q;
   assign ack      = ack_q;
   assign conflict = conflict_q;
   assign mismatch = mismatch_q;
   assign q_exp    = q_exp_q;
   assign q_valid  = q_valid_q;

endmodule

// File: doc/sr_latch_driver.md
Name: sr_latch_driver

Overview:
Sequencing stage directly upstream of sr_latch. It converts set/reset requests from control logic into clean, mutually exclusive S/R pulses and never drives S=R=1. Each pulse has a programmable width and is followed by a dead time. After each command it checks the latch output Q fed back from sr_latch and flags any disagreement with the expected value.

Parameters:
PULSE_CYC, 2, clock cycles S or R is held high per command (legal range 1..15)
GAP_CYC, 1, dead-time cycles with S=R=0 after each pulse (legal range 1..15)
CW, 4, width of the shared pulse/gap down-counter

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
set_req  input  1  level request to set the latch; held until ack
rst_req  input  1  level request to reset the latch; held until ack
q_fb  input  1  Q output fed back from sr_latch
S  output  1  registered set drive to sr_latch
R  output  1  registered reset drive to sr_latch
busy  output  1  high in PULSE and GAP states
ack  output  1  one-cycle pulse; command accepted and its pulse has completed
conflict  output  1  one-cycle pulse; set_req and rst_req were both high when sampled in IDLE
mismatch  output  1  one-cycle pulse; q_fb differed from expected at end of GAP
q_exp  output  1  expected latch state after the last completed command
q_valid  output  1  high once at least one command has completed since reset

Behaviour:
- Reset (asynchronous, rst=1):
  - S, R, busy, ack, conflict, mismatch, q_exp and q_valid all go to 0 immediately.
  - FSM returns to IDLE and the counter clears.
  - Reset mid-pulse drops S/R in the same cycle, with no ack.
- FSM states: IDLE, PULSE, GAP. State and all outputs are registered.
- IDLE:
  - S=R=0, busy=0.
  - On an edge with rst_req=1: go to PULSE as a reset command, cnt<=PULSE_CYC-1, R<=1.
  - Else on an edge with set_req=1: go to PULSE as a set command, cnt<=PULSE_CYC-1, S<=1.
  - Simultaneous requests: reset wins and conflict pulses for one cycle, aligned with the first R-high cycle.
- PULSE:
  - The selected drive (S or R) stays high; busy=1.
  - Each edge with cnt!=0 decrements cnt.
  - On the edge with cnt==0: go to GAP, S=R=0, ack=1 for that one cycle, cnt<=GAP_CYC-1, q_exp<=cmd (1 for set), q_valid<=1.
- GAP:
  - S=R=0, busy=1.
  - On the edge with cnt==0: go to IDLE; mismatch<=(q_fb!=q_exp) for one cycle.
- Requests:
  - set_req and rst_req are ignored in PULSE and GAP; only IDLE samples them.
  - A request still high when IDLE is re-entered issues a new command; requesters must drop req on the edge after they see ack.
- Latency (PULSE_CYC=2, GAP_CYC=1), request sampled at edge 0:
  - S high in cycles 1–2.
  - ack and the gap in cycle 3.
  - IDLE plus mismatch evaluation in cycle 4.
  - A new command can start at edge 4 at the earliest.
- Invariant: S&R is never 1 in any cycle, including reset entry and exit.
- Repeating a command equal to q_exp still issues a full pulse; no suppression.
- q_fb is treated as already synchronous to clk (sr_latch is in the same domain); no synchronizer.

Decomposition:
- Shared package sr_pkg holds:
  - the state enum (IDLE, PULSE, GAP);
  - the command enum (CMD_SET=1, CMD_RST=0);
  - the default PULSE_CYC and GAP_CYC constants.
- Optional sub-module sr_dcount: a CW-bit loadable down-counter with zero flag.
- The FSM and output registers stay in sr_latch_driver.
- The bench instantiates sr_latch_driver driving the existing sr_latch, with Q wired to q_fb.

Test Plan:
- Reset release with no requests -> S=R=0, busy=0, q_valid=0 for 10 cycles.
- set_req high at edge 0, dropped after ack -> S=1 in cycles 1–2, ack in cycle 3, busy in cycles 1–3, q_exp=1, q_valid=1, Q=1, mismatch=0.
- set_req and rst_req both high at edge 0 -> R=1 in cycles 1–2, S=0 throughout, conflict=1 in cycle 1, q_exp=0.
- Back-to-back: set then reset held continuously -> second pulse starts at edge 4, and every cycle satisfies S&R=0 (assertion).
- Force q_fb=0 after a set command -> mismatch=1 in cycle 4 only.
- Assert rst in cycle 2 of a set pulse -> S=0 in the same cycle, no ack, state IDLE, q_valid=0.
